// File: rtl/pipe_credit_rx.sv
// Receive-side terminator for a fixed-latency delay pipeline: issues launch credits and
// re-exposes pipeline output as a valid/ready stream. Define PIPE_CREDIT_RX_BYPASS_EN for 0-cycle empty bypass.
module pipe_credit_rx #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,   // power of 2, >= 2, >= LATENCY+1 for full throughput
  parameter int LATENCY = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       issue_valid_in,
  output logic                       issue_ready_out,
  input  logic                       pipe_valid_in,
  input  logic [WIDTH-1:0]           pipe_data_in,
  output logic                       m_valid_out,
  output logic [WIDTH-1:0]           m_data_out,
  input  logic                       m_ready_in,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count, inflight;
  logic             overflow;

  logic empty, full, issue_fire, pop, fifo_rd, fifo_wr, byp_take, drop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Credits come from registered state only, so a pop returns its credit one cycle later.
  assign issue_ready_out = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
  assign issue_fire      = issue_valid_in & issue_ready_out;

`ifdef PIPE_CREDIT_RX_BYPASS_EN
  assign m_valid_out = !empty | pipe_valid_in;
  assign m_data_out  = !empty ? mem[rd_ptr] : (pipe_valid_in ? pipe_data_in : '0);
  assign byp_take    = empty & pipe_valid_in & m_ready_in;
`else
  assign m_valid_out = !empty;
  assign m_data_out  = empty ? '0 : mem[rd_ptr];
  assign byp_take    = 1'b0;
`endif

  assign pop     = m_valid_out & m_ready_in;
  assign fifo_rd = pop & !empty;
  // A word consumed straight through the bypass never touches the storage.
  assign fifo_wr = pipe_valid_in & (!full | pop) & !byp_take;
  assign drop    = pipe_valid_in & full & !pop;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(fifo_wr) - CW'(fifo_rd);
      if (drop) overflow <= 1'b1;
      unique case ({issue_fire, pipe_valid_in})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; the output is masked to zero while empty, so stale words never leak.
  always_ff @(posedge clk_in) begin
    if (fifo_wr) mem[wr_ptr] <= pipe_data_in;
  end

  assign count_out    = count;
  assign overflow_out = overflow;

`ifndef SYNTHESIS
  // A non-stallable pipeline can never hold more than LATENCY launches at once.
  a_inflight_bound: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    inflight <= CW'(LATENCY))
    else $error("pipe_credit_rx: inflight exceeds pipeline latency");
`endif

endmodule
